// File: rtl/sd_sector_packer.sv
// sd_sector_packer: ping-pong byte-to-sector buffer feeding the SD write stage.
// The writer fills sectors into two banks of one memory. A flush zero-pads the
// current sector. The reader sees the oldest full bank through a registered
// random-access port and hands it back with sec_release.
module sd_sector_packer #(
    parameter int SECTOR_BYTES = 512,
    parameter int ADDR_W       = 9
) (
    input  logic              clk_peri,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic              sec_valid,
    input  logic [ADDR_W-1:0] sec_rd_addr,
    output logic [7:0]        sec_rd_data,
    input  logic              sec_release,
    output logic [15:0]       sec_count,
    output logic              busy_pad
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(SECTOR_BYTES - 1);

    typedef enum logic {ST_FILL, ST_PAD} state_t;

    state_t              state_q, state_d;
    logic                wbank_q, wbank_d;
    logic                rbank_q, rbank_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic [1:0]          full_q, full_d;
    logic [15:0]         sec_count_q, sec_count_d;
    logic [7:0]          rd_data_q;

    logic                wr_en;
    logic [7:0]          wr_data;
    logic                sector_done;
    logic                release_ok;

    // Both banks live in one array; the bank bit is the address MSB.
    logic [7:0] mem [0:2*SECTOR_BYTES-1];

    // FSM state register.
    always_ff @(posedge clk_peri or posedge reset) begin
        if (reset) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: flush looks at the pointer after any same-cycle write,
    // so a flush that lands exactly on a sector boundary never pads an empty sector.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: if (flush && (wptr_d != '0)) state_d = ST_PAD;
            ST_PAD:  if (sector_done)             state_d = ST_FILL;
            default: state_d = ST_FILL;
        endcase
    end

    // FSM outputs: handshake, pad indicator and the memory write strobe.
    always_comb begin
        in_ready = (state_q == ST_FILL) && !full_q[wbank_q];
        busy_pad = (state_q == ST_PAD);
        wr_en    = busy_pad ? 1'b1 : (in_valid && in_ready);
        wr_data  = busy_pad ? 8'h00 : in_data;
    end

    // Pointer, bank, full-flag and counter next-state logic.
    // Completion and release always target different banks, so both may apply at once.
    always_comb begin
        sector_done = wr_en && (wptr_q == LAST_PTR);
        release_ok  = sec_release && full_q[rbank_q];
        wptr_d      = wr_en ? wptr_q + 1'b1 : wptr_q;
        wbank_d     = wbank_q ^ sector_done;
        rbank_d     = rbank_q ^ release_ok;
        full_d      = full_q;
        if (sector_done) full_d[wbank_q] = 1'b1;
        if (release_ok)  full_d[rbank_q] = 1'b0;
        sec_count_d = sec_count_q + {15'd0, sector_done};
    end

    // Write-side and read-side control registers.
    always_ff @(posedge clk_peri or posedge reset) begin
        if (reset) begin
            wptr_q      <= '0;
            wbank_q     <= 1'b0;
            rbank_q     <= 1'b0;
            full_q      <= 2'b00;
            sec_count_q <= 16'd0;
        end else begin
            wptr_q      <= wptr_d;
            wbank_q     <= wbank_d;
            rbank_q     <= rbank_d;
            full_q      <= full_d;
            sec_count_q <= sec_count_d;
        end
    end

    // Memory write port; contents are deliberately left unreset.
    always_ff @(posedge clk_peri) begin
        if (wr_en) mem[{wbank_q, wptr_q}] <= wr_data;
    end

    // Registered read port into the presented bank.
    always_ff @(posedge clk_peri or posedge reset) begin
        if (reset) begin
            rd_data_q <= 8'h00;
        end else begin
            rd_data_q <= mem[{rbank_q, sec_rd_addr}];
        end
    end

    assign sec_valid   = full_q[rbank_q];
    assign sec_rd_data = rd_data_q;
    assign sec_count   = sec_count_q;

endmodule

// File: tb/tb_sd_sector_packer.sv
// Directed self-checking bench for sd_sector_packer (512-byte sectors).
module tb_sd_sector_packer;

    logic       clk_peri = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic       sec_valid;
    logic [8:0] sec_rd_addr;
    logic [7:0] sec_rd_data;
    logic       sec_release;
    logic [15:0] sec_count;
    logic       busy_pad;

    int vectors = 0;
    int miscompares = 0;

    sd_sector_packer #(.SECTOR_BYTES(512), .ADDR_W(9)) dut (
        .clk_peri   (clk_peri),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .sec_valid  (sec_valid),
        .sec_rd_addr(sec_rd_addr),
        .sec_rd_data(sec_rd_data),
        .sec_release(sec_release),
        .sec_count  (sec_count),
        .busy_pad   (busy_pad)
    );

    always #5 clk_peri = ~clk_peri;

    function automatic logic [7:0] byte_of(input int idx);
        return 8'((idx * 3) + (idx / 512));
    endfunction

    task automatic step();
        @(posedge clk_peri);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_data = 8'h00; in_valid = 1'b0; flush = 1'b0;
        sec_rd_addr = '0; sec_release = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (in_ready !== 1'b1 || sec_valid !== 1'b0 || sec_rd_data !== 8'h00 ||
            sec_count !== 16'd0 || busy_pad !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy=%b sv=%b rd=%h cnt=%0d pad=%b want 1 0 00 0 0",
                     in_ready, sec_valid, sec_rd_data, sec_count, busy_pad);
        end
        $display("test_reset done");
    endtask

    task automatic test_stream();
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 512; i++) begin
            in_data = 8'(i);
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL stream_ready byte %0d: got %b want 1", i, in_ready);
            end
            if (i == 511) begin
                vectors++;
                if (sec_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stream_valid_early: got %b want 0", sec_valid);
                end
            end
            step();
        end
        in_valid = 1'b0;
        vectors++;
        if (sec_valid !== 1'b1 || sec_count !== 16'd1) begin
            miscompares++;
            $display("FAIL stream_complete: got sv=%b cnt=%0d want 1 1", sec_valid, sec_count);
        end
        for (int a = 0; a < 512; a++) begin
            sec_rd_addr = 9'(a);
            step();
            vectors++;
            if (sec_rd_data !== 8'(a)) begin
                miscompares++;
                $display("FAIL stream_read addr %0d: got %h want %h", a, sec_rd_data, 8'(a));
            end
        end
        sec_release = 1'b1; step(); sec_release = 1'b0;
        vectors++;
        if (sec_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_release: got sv=%b want 0", sec_valid);
        end
        $display("test_stream done");
    endtask

    task automatic test_stall();
        int accepted;
        logic [7:0] exp_b;
        do_reset();
        accepted = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 1536; c++) begin
            in_data = byte_of(accepted);
            vectors++;
            if (in_ready !== (accepted < 1024)) begin
                miscompares++;
                $display("FAIL stall_ready cycle %0d: got %b want %b", c, in_ready, accepted < 1024);
            end
            if (in_ready === 1'b1) accepted++;
            step();
        end
        in_valid = 1'b0;
        vectors++;
        if (accepted != 1024 || sec_count !== 16'd2 || sec_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_totals: got acc=%0d cnt=%0d sv=%b want 1024 2 1",
                     accepted, sec_count, sec_valid);
        end
        for (int k = 0; k < 3; k++) begin
            sec_rd_addr = (k == 0) ? 9'd0 : (k == 1) ? 9'd1 : 9'd511;
            exp_b = byte_of(int'(sec_rd_addr));
            step();
            vectors++;
            if (sec_rd_data !== exp_b) begin
                miscompares++;
                $display("FAIL stall_bank0 addr %0d: got %h want %h", sec_rd_addr, sec_rd_data, exp_b);
            end
        end
        sec_release = 1'b1; step(); sec_release = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || sec_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_release: got rdy=%b sv=%b want 1 1", in_ready, sec_valid);
        end
        for (int k = 0; k < 3; k++) begin
            sec_rd_addr = (k == 0) ? 9'd0 : (k == 1) ? 9'd255 : 9'd511;
            exp_b = byte_of(512 + int'(sec_rd_addr));
            step();
            vectors++;
            if (sec_rd_data !== exp_b) begin
                miscompares++;
                $display("FAIL stall_bank1 addr %0d: got %h want %h", sec_rd_addr, sec_rd_data, exp_b);
            end
        end
        $display("test_stall done");
    endtask

    task automatic test_flush_pad();
        int n;
        logic [7:0] exp_b;
        do_reset();
        in_valid = 1'b1; in_data = 8'hA5;
        repeat (10) step();
        in_valid = 1'b0;
        flush = 1'b1; step(); flush = 1'b0;
        n = 0;
        while (busy_pad === 1'b1 && n < 1000) begin
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL pad_ready cycle %0d: got %b want 0", n, in_ready);
            end
            n++;
            step();
        end
        vectors++;
        if (n != 502) begin
            miscompares++;
            $display("FAIL pad_length: got %0d want 502", n);
        end
        vectors++;
        if (sec_valid !== 1'b1 || sec_count !== 16'd1 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL pad_done: got sv=%b cnt=%0d rdy=%b want 1 1 1", sec_valid, sec_count, in_ready);
        end
        for (int a = 0; a < 512; a++) begin
            sec_rd_addr = 9'(a);
            exp_b = (a < 10) ? 8'hA5 : 8'h00;
            step();
            vectors++;
            if (sec_rd_data !== exp_b) begin
                miscompares++;
                $display("FAIL pad_read addr %0d: got %h want %h", a, sec_rd_data, exp_b);
            end
        end
        $display("test_flush_pad done");
    endtask

    task automatic test_flush_empty();
        int n;
        do_reset();
        flush = 1'b1; step(); flush = 1'b0;
        vectors++;
        if (busy_pad !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_empty_nopad: got pad=%b rdy=%b want 0 1", busy_pad, in_ready);
        end
        step(); step();
        vectors++;
        if (sec_valid !== 1'b0 || sec_count !== 16'd0) begin
            miscompares++;
            $display("FAIL flush_empty_nosector: got sv=%b cnt=%0d want 0 0", sec_valid, sec_count);
        end
        // flush together with the first byte of a sector
        in_valid = 1'b1; in_data = 8'h3C; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        n = 0;
        while (busy_pad === 1'b1 && n < 1000) begin
            n++;
            step();
        end
        vectors++;
        if (n != 511) begin
            miscompares++;
            $display("FAIL flush_first_pad_length: got %0d want 511", n);
        end
        vectors++;
        if (sec_count !== 16'd1 || sec_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_first_done: got cnt=%0d sv=%b want 1 1", sec_count, sec_valid);
        end
        sec_rd_addr = 9'd0; step();
        vectors++;
        if (sec_rd_data !== 8'h3C) begin
            miscompares++;
            $display("FAIL flush_first_byte0: got %h want 3c", sec_rd_data);
        end
        sec_rd_addr = 9'd1; step();
        vectors++;
        if (sec_rd_data !== 8'h00) begin
            miscompares++;
            $display("FAIL flush_first_byte1: got %h want 00", sec_rd_data);
        end
        $display("test_flush_empty done");
    endtask

    task automatic test_overlap();
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 1023; i++) begin
            in_data = byte_of(i);
            step();
        end
        in_data = byte_of(1023);
        sec_release = 1'b1;
        vectors++;
        if (sec_valid !== 1'b1 || in_ready !== 1'b1 || sec_count !== 16'd1) begin
            miscompares++;
            $display("FAIL overlap_before: got sv=%b rdy=%b cnt=%0d want 1 1 1", sec_valid, in_ready, sec_count);
        end
        step();
        in_valid = 1'b0; sec_release = 1'b0;
        vectors++;
        if (sec_valid !== 1'b1 || in_ready !== 1'b1 || sec_count !== 16'd2) begin
            miscompares++;
            $display("FAIL overlap_after: got sv=%b rdy=%b cnt=%0d want 1 1 2", sec_valid, in_ready, sec_count);
        end
        sec_rd_addr = 9'd511; step();
        vectors++;
        if (sec_rd_data !== byte_of(1023)) begin
            miscompares++;
            $display("FAIL overlap_read511: got %h want %h", sec_rd_data, byte_of(1023));
        end
        sec_release = 1'b1; step(); sec_release = 1'b0;
        vectors++;
        if (sec_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL overlap_drain: got sv=%b want 0", sec_valid);
        end
        $display("test_overlap done");
    endtask

    task automatic test_reset_mid_pad();
        logic [7:0] exp_b;
        do_reset();
        in_valid = 1'b1; in_data = 8'h77;
        repeat (300) step();
        in_valid = 1'b0;
        flush = 1'b1; step(); flush = 1'b0;
        sec_rd_addr = 9'd0;
        repeat (20) step();
        vectors++;
        if (busy_pad !== 1'b1) begin
            miscompares++;
            $display("FAIL midpad_busy: got %b want 1", busy_pad);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || sec_valid !== 1'b0 || sec_rd_data !== 8'h00 ||
            sec_count !== 16'd0 || busy_pad !== 1'b0) begin
            miscompares++;
            $display("FAIL midpad_async_reset: got rdy=%b sv=%b rd=%h cnt=%0d pad=%b want 1 0 00 0 0",
                     in_ready, sec_valid, sec_rd_data, sec_count, busy_pad);
        end
        step(); step();
        reset = 1'b0;
        step();
        in_valid = 1'b1;
        for (int i = 0; i < 512; i++) begin
            in_data = 8'(i) ^ 8'h55;
            step();
        end
        in_valid = 1'b0;
        vectors++;
        if (sec_count !== 16'd1 || sec_valid !== 1'b1 || busy_pad !== 1'b0) begin
            miscompares++;
            $display("FAIL midpad_restart: got cnt=%0d sv=%b pad=%b want 1 1 0", sec_count, sec_valid, busy_pad);
        end
        for (int k = 0; k < 4; k++) begin
            sec_rd_addr = (k == 0) ? 9'd0 : (k == 1) ? 9'd299 : (k == 2) ? 9'd300 : 9'd511;
            exp_b = 8'(sec_rd_addr) ^ 8'h55;
            step();
            vectors++;
            if (sec_rd_data !== exp_b) begin
                miscompares++;
                $display("FAIL midpad_read addr %0d: got %h want %h", sec_rd_addr, sec_rd_data, exp_b);
            end
        end
        $display("test_reset_mid_pad done");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush_pad();
        test_flush_empty();
        test_overlap();
        test_reset_mid_pad();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sd_sector_packer.md
# sd_sector_packer

Ping-pong byte-to-sector buffer sitting directly upstream of the SD card SPI master peripheral. Accepts a byte stream from the logging datapath with a valid/ready handshake and packs it into fixed-size sectors held in two BlockRAM-backed banks. A full sector is presented to the SD write stage through a random-access read port. The consumer releases the bank once the block write completes. A flush request zero-pads a partially filled sector so buffered log data can be committed.

## Interface
Parameters:
- SECTOR_BYTES, 512, bytes per sector; power of two, minimum 4.
- ADDR_W, 9, log2(SECTOR_BYTES); width of byte pointers and read address.

Ports:
- clk_peri  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  byte accepted on a cycle where in_valid & in_ready.
- flush  input  1  single-cycle pulse; pad the current sector to full.
- sec_valid  output  1  one full sector is readable in bank rbank.
- sec_rd_addr  input  ADDR_W  byte address within the presented sector.
- sec_rd_data  output  8  byte at sec_rd_addr, registered.
- sec_release  input  1  pulse; consumer is done with the presented sector.
- sec_count  output  16  number of sectors completed since reset; wraps 0xFFFF->0.
- busy_pad  output  1  padding in progress.

## Operation
- Storage: 2*SECTOR_BYTES x 8 memory. Bank select is the MSB, byte pointer the LSBs. One write port and one registered read port.
- Write-side state: wbank (1 bit), wptr (ADDR_W bits), full[1:0], FSM {FILL, PAD}.
- in_ready = (state==FILL) & !full[wbank]. This is combinational from registers.
- FILL: on accept, write in_data at {wbank,wptr} and increment wptr.
  - When wptr==SECTOR_BYTES-1 is written: set full[wbank], toggle wbank, wptr wraps to 0, increment sec_count.
- flush in FILL is evaluated after any same-cycle write, using the updated pointer.
  - Updated wptr != 0: go to PAD.
  - Updated wptr == 0: flush is ignored; no empty sectors are ever produced.
- PAD: write 0x00 at {wbank,wptr} every cycle and increment wptr. in_ready stays 0.
  - On writing the last byte, complete the sector exactly as in FILL, then return to FILL.
- flush during PAD is ignored.
- flush while full[wbank]=1 (both banks full): wptr is 0, so flush is ignored.
- Read side: rbank (1 bit). sec_valid = full[rbank]. sec_rd_data <= mem[{rbank,sec_rd_addr}] every cycle.
- sec_release with sec_valid=1: clear full[rbank] and toggle rbank. sec_release with sec_valid=0 is ignored.
- Simultaneous completion (wbank) and release (rbank) of opposite banks both take effect in the same cycle.
  - Same-bank overlap cannot occur: completion requires full[wbank]=0, and release requires full[rbank]=1.
- Sector order is strict FIFO. Bytes are never dropped or reordered.

## Timing
- Reset values:
  - Registers: wptr=0, wbank=0, rbank=0, full=00, state=FILL.
  - Outputs: in_ready=1, sec_valid=0, sec_rd_data=0x00, sec_count=0, busy_pad=0.
- Memory contents are not reset.
- Reset mid-sector or mid-PAD discards partial and full sectors. Outputs return to reset values asynchronously.
- Acceptance of the last sector byte in cycle N:
  - sec_valid rises in cycle N+1 if rbank==wbank-at-N. Otherwise it is already high.
  - sec_count increments at N+1.
- Read latency: sec_rd_data reflects sec_rd_addr presented in cycle N at cycle N+1. Throughput is 1 byte/cycle.
- sec_release in cycle N: sec_valid reflects the other bank in cycle N+1. in_ready recovers in N+1 if the writer was stalled on that bank.
- PAD duration: SECTOR_BYTES - wptr cycles, where wptr is the value on PAD entry. busy_pad is high for exactly those cycles, starting the cycle after flush.
- Write throughput: 1 byte/cycle. Back-to-back sectors complete with no bubble.

## Test plan
- Reset, then 512 bytes 0x00..0xFF,0x00..0xFF with in_valid held high -> in_ready high throughout; sec_valid rises 1 cycle after byte 511; sec_count=1; reading addr 0..511 returns the same pattern with 1-cycle latency.
- 1536 bytes with no release -> 1024 bytes accepted; in_ready falls the cycle after byte 1023; sec_count=2; stall persists. sec_release -> in_ready=1 next cycle; bank-1 data still readable and ordered after bank 0.
- 10 bytes 0xA5, then flush -> busy_pad high for 502 cycles; sector reads 10x0xA5 then 502x0x00; sec_count=1; in_ready=1 afterward.
- flush with wptr=0 -> no PAD, sec_valid stays 0; flush in the same cycle as a byte accept at wptr=0 -> PAD of 511 cycles.
- Sector completes in the same cycle as sec_release of the other bank -> both take effect; sec_valid stays 1 and presents the new bank; no in_ready glitch.
- Assert reset during PAD at wptr=300 -> all outputs at reset values immediately; next 512-byte stream forms a clean sector with sec_count=1.
